gold_seq_gen: RTL
=================

// Module: gold_seq_gen
// PURPOSE
//  Consumer of the 31-bit c_init built by the cinit datapath. Loads c_init into the
//  x2 LFSR, runs the length-31 Gold sequence (36.211 7.2) through the Nc warm-up and
//  streams c(2m),c(2m+1) pairs to the NRS QPSK mapper via valid/ready.
//  One sequence per start; block then idles until the next start.
// PARAMETERS
//  CINIT_W  31    c_init width (fixed by standard, do not change)
//  NC       1600  warm-up length in sequence steps; multiple of 8
//  PAIR_W   8     width of num_pairs / internal pair counter
// PORTS
//  clk        in   1        clock
//  rst        in   1        async active-low reset
//  start      in   1        1-cycle request; sampled only in IDLE
//  cinit      in   CINIT_W  c_init, sampled with start
//  num_pairs  in   PAIR_W   pairs to emit, sampled with start
//  out_ready  in   1        mapper accepts pair
//  out_valid  out  1        out_bits valid
//  out_bits   out  2        [0]=c(2m), [1]=c(2m+1)
//  busy       out  1        high in WARMUP/STREAM
//  done       out  1        1-cycle pulse after last pair accepted (or after warm-up if num_pairs=0)
// BEHAVIOUR
//  Reset (any time, incl. mid-sequence): state=IDLE; out_valid,out_bits,busy,done=0; LFSRs=0; counters=0.
//  LFSRs: x1 load = 31'h0000_0001 (x1(0)=1); x2 load = cinit (bit i = x2(i)).
//   x1(n+31)=x1(n+3)^x1(n); x2(n+31)=x2(n+3)^x2(n+2)^x2(n+1)^x2(n).
//   c(n)=x1(n+NC)^x2(n+NC); one "step" shifts both by one index.
//  FSM:
//   IDLE  : start=1 -> load LFSRs, latch num_pairs, wcnt=0, -> WARMUP. start else ignored.
//   WARMUP: advance STEPW steps/cycle; after NC/STEPW cycles -> STREAM (num_pairs>0) or
//           IDLE with done=1 (num_pairs=0).
//   STREAM: out_valid=1, out_bits = {x1[1]^x2[1], x1[0]^x2[0]}.
//           out_valid&out_ready: advance 2 steps, pcnt++; on last pair -> IDLE, done=1 next cycle.
//           out_valid&!out_ready: LFSRs, out_bits, pcnt frozen (bits stable under backpressure).
//  out_bits driven combinationally from LFSR regs in STREAM, forced 0 otherwise.
//  Latency: start edge k -> out_valid first high at edge k+1+NC/STEPW.
//  start while busy: ignored, no effect on running sequence or latched inputs.
//  done and start same cycle: start accepted (state is IDLE when done pulses).
//  All XOR arithmetic; counters wrap-free (wcnt max NC/STEPW-1, pcnt max num_pairs-1).
// CONFIGURATION
//  GOLD_PAR_WARMUP_EN defined: STEPW=8, 8-step unrolled next-state for warm-up (NC=1600 -> 200 cycles).
//  Not defined: STEPW=2, warm-up reuses the 2-step streaming next-state (NC=1600 -> 800 cycles).
//  Output sequence identical in both builds; only warm-up duration differs.
// TESTING
//  1 cinit=31'h0000_0001, num_pairs=4, ready=1 -> out_valid at k+801 (k+201 w/ macro), 4 pairs equal golden
//    model c(0..7), done pulses 1 cycle after 4th accept, busy falls same edge.
//  2 cinit=31'h1234_5678, num_pairs=200, ready toggled random -> 200 pairs match model c(0..399);
//    out_bits never change while valid&!ready.
//  3 num_pairs=0 -> no out_valid ever; done pulse at k+1+NC/STEPW; busy high exactly NC/STEPW cycles.
//  4 start reasserted with cinit=0 during WARMUP and STREAM -> ignored; output still matches first cinit.
//  5 rst low mid-STREAM after 3 pairs -> all outputs 0 asynchronously; new start with same cinit
//    restarts from c(0).
//  6 done cycle with start=1, cinit=31'h7FFF_FFFF -> second sequence runs back-to-back, matches model.

Source files
------------

// File: rtl/gold_seq_gen_if.sv
// Handshake bundle between the c_init source, the Gold generator
// and the NRS QPSK mapper.
interface gold_seq_gen_if #(
    parameter int CINIT_W = 31,
    parameter int PAIR_W  = 8
);
    logic               start;
    logic [CINIT_W-1:0] cinit;
    logic [PAIR_W-1:0]  num_pairs;
    logic               out_ready;
    logic               out_valid;
    logic [1:0]         out_bits;
    logic               busy;
    logic               done;

    modport master (
        output start, cinit, num_pairs, out_ready,
        input  out_valid, out_bits, busy, done
    );

    modport slave (
        input  start, cinit, num_pairs, out_ready,
        output out_valid, out_bits, busy, done
    );
endinterface

// File: rtl/gold_seq_gen.sv
// Gold sequence generator: x1/x2 LFSRs, Nc warm-up, c(2m)/c(2m+1) pairs out.
// Define GOLD_PAR_WARMUP_EN for an 8-step/cycle warm-up (default 2-step).
module gold_seq_gen #(
    parameter int CINIT_W = 31,
    parameter int NC      = 1600,
    parameter int PAIR_W  = 8
) (
    input logic           clk,
    input logic           rst,
    gold_seq_gen_if.slave bus
);
`ifdef GOLD_PAR_WARMUP_EN
    localparam int STEPW = 8;
`else
    localparam int STEPW = 2;
`endif
    localparam int WCYC   = NC / STEPW;
    localparam int WCNT_W = (WCYC > 1) ? $clog2(WCYC) : 1;
    localparam logic [WCNT_W-1:0] WLAST = WCNT_W'(WCYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        WARMUP,
        STREAM
    } state_t;

    state_t             state_q, state_d;
    logic [CINIT_W-1:0] x1_q, x1_d;
    logic [CINIT_W-1:0] x2_q, x2_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic [PAIR_W-1:0]  pcnt_q, pcnt_d;
    logic [PAIR_W-1:0]  np_q, np_d;
    logic               done_q, done_d;

    logic [CINIT_W-1:0] x1_s2, x2_s2;
    logic [CINIT_W-1:0] x1_w, x2_w;

    // Bit i of each register holds x(n+i); one step shifts in x(n+31).
    function automatic logic [CINIT_W-1:0] x1_step(
        input logic [CINIT_W-1:0] v
    );
        return {v[3] ^ v[0], v[CINIT_W-1:1]};
    endfunction

    function automatic logic [CINIT_W-1:0] x2_step(
        input logic [CINIT_W-1:0] v
    );
        return {v[3] ^ v[2] ^ v[1] ^ v[0], v[CINIT_W-1:1]};
    endfunction

    assign x1_s2 = x1_step(x1_step(x1_q));
    assign x2_s2 = x2_step(x2_step(x2_q));

`ifdef GOLD_PAR_WARMUP_EN
    function automatic logic [CINIT_W-1:0] x1_step8(
        input logic [CINIT_W-1:0] v
    );
        logic [CINIT_W-1:0] r;
        r = v;
        for (int i = 0; i < 8; i++) r = x1_step(r);
        return r;
    endfunction

    function automatic logic [CINIT_W-1:0] x2_step8(
        input logic [CINIT_W-1:0] v
    );
        logic [CINIT_W-1:0] r;
        r = v;
        for (int i = 0; i < 8; i++) r = x2_step(r);
        return r;
    endfunction

    assign x1_w = x1_step8(x1_q);
    assign x2_w = x2_step8(x2_q);
`else
    assign x1_w = x1_s2;
    assign x2_w = x2_s2;
`endif

    // State, LFSR and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            x1_q    <= '0;
            x2_q    <= '0;
            wcnt_q  <= '0;
            pcnt_q  <= '0;
            np_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            wcnt_q  <= wcnt_d;
            pcnt_q  <= pcnt_d;
            np_q    <= np_d;
            done_q  <= done_d;
        end
    end

    // Next state: load on start, warm up, then emit pairs on accept.
    always_comb begin
        state_d = state_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        wcnt_d  = wcnt_q;
        pcnt_d  = pcnt_q;
        np_d    = np_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    x1_d    = CINIT_W'(1);
                    x2_d    = bus.cinit;
                    np_d    = bus.num_pairs;
                    wcnt_d  = '0;
                    pcnt_d  = '0;
                    state_d = WARMUP;
                end
            end
            WARMUP: begin
                x1_d   = x1_w;
                x2_d   = x2_w;
                wcnt_d = wcnt_q + 1'b1;
                if (wcnt_q == WLAST) begin
                    wcnt_d = '0;
                    if (np_q == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = STREAM;
                    end
                end
            end
            STREAM: begin
                if (bus.out_ready) begin
                    x1_d = x1_s2;
                    x2_d = x2_s2;
                    if (pcnt_q == np_q - 1'b1) begin
                        pcnt_d  = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        pcnt_d = pcnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.out_valid = (state_q == STREAM);
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.out_bits  = (state_q == STREAM)
                         ? {x1_q[1] ^ x2_q[1], x1_q[0] ^ x2_q[0]}
                         : 2'b00;
endmodule
